// File: rtl/demo_magic_monitor.sv
// demo_magic_monitor: watches a free-running 20-bit demo counter, reports each
// arrival at one of four magic values and each FFFFF->0 wrap as an event in a
// small FIFO, tracks the expected M0..M3,wrap ordering with an FSM, counts laps
// (saturating) and raises sticky flags for ordering errors and FIFO overflow.
`timescale 1ns/1ps

module demo_magic_monitor #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] counter,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [2:0]  evt_id,
  output logic [7:0]  evt_lap,
  output logic [7:0]  lap_count,
  output logic        seq_error,
  output logic        evt_overflow
);

  localparam int DATA_W = 20;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam int EW     = 11;  // {id[2:0], lap[7:0]}

  localparam logic [DATA_W-1:0] M0      = 20'd123456;
  localparam logic [DATA_W-1:0] M1      = 20'd234567;
  localparam logic [DATA_W-1:0] M2      = 20'd345678;
  localparam logic [DATA_W-1:0] M3      = 20'd456789;
  localparam logic [DATA_W-1:0] TOP_VAL = 20'hFFFFF;
  localparam logic [DATA_W-1:0] ZERO    = 20'h00000;

  localparam logic [2:0] ID_WRAP = 3'd4;

  typedef enum logic [2:0] {
    WAIT_M0   = 3'd0,
    WAIT_M1   = 3'd1,
    WAIT_M2   = 3'd2,
    WAIT_M3   = 3'd3,
    WAIT_WRAP = 3'd4
  } state_t;

  // Saturating lap increment: stays at 255 once reached.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ---- stage p0: current counter sample vs. previous sample ----
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic [3:0]        hit;
  logic              wrap;
  logic              push;
  logic [2:0]        push_id;
  logic [EW-1:0]     push_data;

  // Previous counter sample; pure data, so no reset.
  always_ff @(posedge clock) begin
    prev <= counter;
  end

  // prev becomes meaningful one cycle after reset releases.
  always_ff @(posedge clock) begin
    if (reset) prev_valid <= 1'b0;
    else       prev_valid <= 1'b1;
  end

  // Edge-style detection: a magic hit only on arrival, a wrap only on FFFFF->0.
  always_comb begin
    hit[0] = prev_valid && (counter == M0) && (prev != M0);
    hit[1] = prev_valid && (counter == M1) && (prev != M1);
    hit[2] = prev_valid && (counter == M2) && (prev != M2);
    hit[3] = prev_valid && (counter == M3) && (prev != M3);
    wrap   = prev_valid && (prev == TOP_VAL) && (counter == ZERO);
  end

  // Encode the (single) event of this cycle; hits and wrap never coincide.
  always_comb begin
    push_id = 3'd0;
    if      (wrap)   push_id = ID_WRAP;
    else if (hit[3]) push_id = 3'd3;
    else if (hit[2]) push_id = 3'd2;
    else if (hit[1]) push_id = 3'd1;
    else             push_id = 3'd0;
    push      = (|hit) || wrap;
    push_data = {push_id, lap_count};
  end

  // ---- sequence FSM ----
  state_t state;
  state_t state_nxt;
  logic   seq_bad;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= WAIT_M0;
    else       state <= state_nxt;
  end

  // Advance only on the expected event; anything else leaves the state alone.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_M0:   if (hit[0]) state_nxt = WAIT_M1;
      WAIT_M1:   if (hit[1]) state_nxt = WAIT_M2;
      WAIT_M2:   if (hit[2]) state_nxt = WAIT_M3;
      WAIT_M3:   if (hit[3]) state_nxt = WAIT_WRAP;
      WAIT_WRAP: if (wrap)   state_nxt = WAIT_M0;
      default:   state_nxt = WAIT_M0;
    endcase
  end

  // Flag any event that is not the one the current state is waiting for.
  always_comb begin
    seq_bad = 1'b0;
    case (state)
      WAIT_M0:   seq_bad = hit[1] || hit[2] || hit[3] || wrap;
      WAIT_M1:   seq_bad = hit[0] || hit[2] || hit[3] || wrap;
      WAIT_M2:   seq_bad = hit[0] || hit[1] || hit[3] || wrap;
      WAIT_M3:   seq_bad = hit[0] || hit[1] || hit[2] || wrap;
      WAIT_WRAP: seq_bad = |hit;
      default:   seq_bad = 1'b0;
    endcase
  end

  // Lap counter counts every wrap, in order or not.
  always_ff @(posedge clock) begin
    if (reset)     lap_count <= 8'd0;
    else if (wrap) lap_count <= sat_inc8(lap_count);
  end

  // Sticky ordering-error flag.
  always_ff @(posedge clock) begin
    if (reset)        seq_error <= 1'b0;
    else if (seq_bad) seq_error <= 1'b1;
  end

  // ---- stage p1: event FIFO ----
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic [EW-1:0] head;

  always_comb begin
    full    = (count == CW'(FIFO_DEPTH));
    pop     = evt_valid && evt_ready;
    push_ok = push && (!full || pop);
  end

  // Storage array; contents only matter between the pointers, so no reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag: an event arrived with no room and no pop to make room.
  always_ff @(posedge clock) begin
    if (reset)                       evt_overflow <= 1'b0;
    else if (push && full && !pop)   evt_overflow <= 1'b1;
  end

  // Head presentation; zeroed while empty so reset shows id/lap of 0.
  always_comb begin
    evt_valid = (count != '0);
    head      = mem[rd_ptr];
    evt_id    = evt_valid ? head[EW-1:8] : 3'd0;
    evt_lap   = evt_valid ? head[7:0]    : 8'd0;
  end

endmodule

// File: tb/tb_demo_magic_monitor.sv
// Scoreboard bench for demo_magic_monitor: stimulus pushes hand-computed
// {id, lap} expectations, a negedge monitor pops and compares on each handshake.
`timescale 1ns/1ps

module tb_demo_magic_monitor;

  localparam logic [19:0] M0 = 20'd123456;
  localparam logic [19:0] M1 = 20'd234567;
  localparam logic [19:0] M2 = 20'd345678;
  localparam logic [19:0] M3 = 20'd456789;
  localparam logic [19:0] TOPV = 20'hFFFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] counter;
  logic        evt_valid;
  logic        evt_ready;
  logic [2:0]  evt_id;
  logic [7:0]  evt_lap;
  logic [7:0]  lap_count;
  logic        seq_error;
  logic        evt_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [10:0] exp_q [$];

  demo_magic_monitor #(.FIFO_DEPTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .counter      (counter),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_id       (evt_id),
    .evt_lap      (evt_lap),
    .lap_count    (lap_count),
    .seq_error    (seq_error),
    .evt_overflow (evt_overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [2:0] id, input logic [7:0] lap);
    exp_q.push_back({id, lap});
  endtask

  task automatic step(input logic [19:0] v);
    counter = v;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    counter = 20'd0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clock);
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every accepted head event must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got id=%0d lap=%0d want none", evt_id, evt_lap);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        chk("evt_id", 32'(evt_id), 32'(e[10:8]));
        chk("evt_lap", 32'(evt_lap), 32'(e[7:0]));
      end
    end
  end

  // Global watchdog.
  initial begin
    #400000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    counter   = 20'd0;
    evt_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_id", 32'(evt_id), 32'd0);
    chk("rst_evt_lap", 32'(evt_lap), 32'd0);
    chk("rst_lap_count", 32'(lap_count), 32'd0);
    chk("rst_seq_error", 32'(seq_error), 32'd0);
    chk("rst_overflow", 32'(evt_overflow), 32'd0);

    // Counter already at M0 in the first cycle after reset: no event.
    counter = M0;
    reset   = 1'b0;
    repeat (4) step(M0);
    chk("first_cycle_no_evt", 32'(evt_valid), 32'd0);
    chk("first_cycle_state", 32'(dut.state), 32'd0);

    // Ramp onto M0 and hold: exactly one event.
    do_reset();
    evt_ready = 1'b1;
    step(20'd123455);
    exp_push(3'd0, 8'd0); step(M0);
    repeat (5) step(M0);
    wait_drain("hold_drain");
    chk("hold_state", 32'(dut.state), 32'd1);
    chk("hold_seq_error", 32'(seq_error), 32'd0);

    // Complete the lap in order.
    exp_push(3'd1, 8'd0); step(M1);
    exp_push(3'd2, 8'd0); step(M2);
    exp_push(3'd3, 8'd0); step(M3);
    step(TOPV);
    exp_push(3'd4, 8'd0); step(20'd0);
    step(20'd0);
    wait_drain("lap_drain");
    chk("lap_count_1", 32'(lap_count), 32'd1);
    chk("lap_seq_error", 32'(seq_error), 32'd0);
    chk("lap_state", 32'(dut.state), 32'd0);

    // Out-of-order hit and wrap.
    do_reset();
    evt_ready = 1'b1;
    step(20'd0);
    exp_push(3'd1, 8'd0); step(M1);
    step(M1);
    chk("ooo_seq_error", 32'(seq_error), 32'd1);
    chk("ooo_state", 32'(dut.state), 32'd0);
    step(TOPV);
    exp_push(3'd4, 8'd0); step(20'd0);
    step(20'd0);
    chk("ooo_wrap_lap", 32'(lap_count), 32'd1);
    chk("ooo_wrap_state", 32'(dut.state), 32'd0);
    wait_drain("ooo_drain");

    // Overflow: five events into a four-entry FIFO with no consumer.
    do_reset();
    evt_ready = 1'b0;
    step(20'd0);
    exp_push(3'd0, 8'd0); step(M0);
    exp_push(3'd1, 8'd0); step(M1);
    exp_push(3'd2, 8'd0); step(M2);
    exp_push(3'd3, 8'd0); step(M3);
    step(TOPV);
    step(20'd0);
    step(20'd0);
    chk("ovf_valid", 32'(evt_valid), 32'd1);
    chk("ovf_flag", 32'(evt_overflow), 32'd1);
    chk("ovf_head_held", 32'(evt_id), 32'd0);
    chk("ovf_lap_count", 32'(lap_count), 32'd1);
    evt_ready = 1'b1;
    wait_drain("ovf_drain");
    chk("ovf_sticky", 32'(evt_overflow), 32'd1);
    chk("ovf_empty", 32'(evt_valid), 32'd0);

    // Full FIFO, event and pop in the same cycle: accepted.
    do_reset();
    evt_ready = 1'b0;
    step(20'd0);
    exp_push(3'd0, 8'd0); step(M0);
    exp_push(3'd1, 8'd0); step(M1);
    exp_push(3'd2, 8'd0); step(M2);
    exp_push(3'd3, 8'd0); step(M3);
    step(TOPV);
    evt_ready = 1'b1;
    exp_push(3'd4, 8'd0); step(20'd0);
    wait_drain("full_pop_drain");
    chk("full_pop_overflow", 32'(evt_overflow), 32'd0);

    // 300 laps: lap counter saturates.
    do_reset();
    evt_ready = 1'b1;
    step(20'd0);
    for (int k = 0; k < 300; k++) begin
      logic [7:0] lp;
      lp = (k > 255) ? 8'd255 : 8'(k);
      exp_push(3'd0, lp); step(M0);
      exp_push(3'd1, lp); step(M1);
      exp_push(3'd2, lp); step(M2);
      exp_push(3'd3, lp); step(M3);
      step(TOPV);
      exp_push(3'd4, lp); step(20'd0);
    end
    wait_drain("sat_drain");
    chk("sat_lap_count", 32'(lap_count), 32'd255);
    chk("sat_seq_error", 32'(seq_error), 32'd0);

    // Reset in the middle of a lap with events pending.
    evt_ready = 1'b0;
    step(M0);
    step(M1);
    step(M1);
    chk("mid_pending", 32'(evt_valid), 32'd1);
    reset     = 1'b1;
    evt_ready = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1;
    chk("mid_evt_valid", 32'(evt_valid), 32'd0);
    chk("mid_evt_id", 32'(evt_id), 32'd0);
    chk("mid_evt_lap", 32'(evt_lap), 32'd0);
    chk("mid_lap_count", 32'(lap_count), 32'd0);
    chk("mid_seq_error", 32'(seq_error), 32'd0);
    chk("mid_overflow", 32'(evt_overflow), 32'd0);
    chk("mid_state", 32'(dut.state), 32'd0);
    counter = 20'd0;
    reset   = 1'b0;
    repeat (3) step(20'd0);
    chk("post_reset_empty", 32'(evt_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demo_magic_monitor.md
DEMO_MAGIC_MONITOR -- requirements
Module: demo_magic_monitor

Interface
REQ-001 SHALL provide parameter: FIFO_DEPTH, 4, event FIFO entries (power of 2, 2..16).
REQ-002 SHALL provide port: clock  input  1  single clock; all state updates on posedge.
REQ-003 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: counter  input  20  count value from the upstream demo counter, sampled every cycle.
REQ-005 SHALL provide port: evt_valid  output  1  event FIFO non-empty.
REQ-006 SHALL provide port: evt_ready  input  1  consumer accepts head event.
REQ-007 SHALL provide port: evt_id  output  3  head event: 0..3 = magic value M0..M3 hit, 4 = wrap.
REQ-008 SHALL provide port: evt_lap  output  8  lap_count value at the time the head event was detected.
REQ-009 SHALL provide port: lap_count  output  8  completed wraps, saturating.
REQ-010 SHALL provide port: seq_error  output  1  sticky: out-of-order magic hit or wrap.
REQ-011 SHALL provide port: evt_overflow  output  1  sticky: event dropped because FIFO full.

Function
REQ-012 SHALL use magic values M0=123456, M1=234567, M2=345678, M3=456789.
REQ-013 SHALL register counter into prev each cycle, with prev_valid set one cycle after reset deasserts.
REQ-014 SHALL flag a hit on Mi only when prev_valid, counter==Mi and prev!=Mi (one event per arrival, none while counter holds).
REQ-015 SHALL flag a wrap only when prev_valid, prev==20'hFFFFF and counter==20'h00000.
REQ-016 SHALL run FSM states WAIT_M0, WAIT_M1, WAIT_M2, WAIT_M3, WAIT_WRAP; reset state WAIT_M0.
REQ-017 SHALL advance WAIT_Mi to the next state on a hit of Mi, WAIT_M3 going to WAIT_WRAP.
REQ-018 SHALL move WAIT_WRAP to WAIT_M0 on wrap and increment lap_count, saturating at 255.
REQ-019 SHALL, on a hit of Mj in state WAIT_Mi with j!=i, or a wrap in any state other than WAIT_WRAP, set seq_error and leave the FSM state unchanged.
REQ-020 SHALL still increment lap_count on an out-of-order wrap.
REQ-021 SHALL push {id, lap} for every hit or wrap, correct or not, with lap equal to lap_count before that cycle's increment.
REQ-022 SHALL produce at most one event per cycle, since hit and wrap are mutually exclusive by value.
REQ-023 SHALL pop on evt_valid && evt_ready and hold evt_id/evt_lap stable while evt_valid && !evt_ready.
REQ-024 SHALL accept a push when the FIFO is full only if a pop occurs the same cycle; otherwise it SHALL drop the event, set evt_overflow, and leave FIFO contents unchanged.
REQ-025 SHALL handle simultaneous push and pop on an empty FIFO as push-only, with no bypass: evt_valid rises the next cycle.
REQ-026 SHALL present event output with 1-cycle latency: event detected at cycle N gives evt_valid at N+1 if the FIFO was empty.
REQ-027 SHALL drive seq_error and evt_overflow from registers, set only, cleared only by reset.

Reset
REQ-028 SHALL, on reset, clear FIFO (evt_valid=0), evt_id=0, evt_lap=0, lap_count=0, seq_error=0, evt_overflow=0, prev_valid=0, and set the FSM to WAIT_M0.
REQ-029 SHALL, on reset asserted mid-operation, discard pending events and in-progress FSM state in that cycle, and ignore evt_ready during reset.
REQ-030 SHALL not detect events in the first cycle after reset, even if counter already equals a magic value.

Verification
REQ-031 SHALL cover: counter ramps 123455->123456 then holds 5 cycles, evt_ready=1 -> exactly one event id=0 lap=0, FSM WAIT_M1.
REQ-032 SHALL cover: full sequence M0..M3 then FFFFF->0, ready=1 -> ids 0,1,2,3,4 all lap=0; lap_count=1; seq_error=0.
REQ-033 SHALL cover: counter jumps to 234567 from reset state -> event id=1, seq_error=1, FSM stays WAIT_M0.
REQ-034 SHALL cover: evt_ready=0, FIFO_DEPTH=4, 5 magic/wrap arrivals -> evt_valid=1, first 4 retained in order, evt_overflow=1.
REQ-035 SHALL cover: FIFO full plus event plus evt_ready=1 same cycle -> event accepted, evt_overflow stays 0.
REQ-036 SHALL cover: 300 correct laps -> lap_count saturates at 255; reset mid-lap -> all outputs 0, FSM WAIT_M0.
